// File: rtl/key_event_gen.sv
// Debounced push-button front end: press/release strobes, level, optional auto-repeat.
// Auto-repeat logic is built only when KEY_EVENT_GEN_AUTOREPEAT_EN is defined.
module key_event_gen #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 5000000
) (
  input  logic clk_btn,
  input  logic rst_btn,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic advance
);

  localparam int unsigned MaxDbDelay = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                                       DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int unsigned MaxCycles  = (MaxDbDelay > REPEAT_RATE_CYCLES) ?
                                       MaxDbDelay : REPEAT_RATE_CYCLES;
  localparam int unsigned CntW       = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
  localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressDb,
    StHeld,
    StReleaseDb
  } state_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == CntMax) ? v : v + CntW'(1);
  endfunction

  logic            sync1_q, sync2_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            advance_q, advance_d;
  logic            key_down;

  assign key_down = ~sync2_q;

  always_ff @(posedge clk_btn or posedge rst_btn) begin
    if (rst_btn) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= StIdle;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      advance_q <= 1'b0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      advance_q <= advance_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_down) state_d = StPressDb;
      end
      StPressDb: begin
        if (!key_down) begin
          state_d = StIdle;
        end else if (db_cnt_q == DbLast) begin
          state_d = StHeld;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          db_cnt_d = sat_inc(db_cnt_q);
        end
      end
      StHeld: begin
        if (!key_down) state_d = StReleaseDb;
      end
      StReleaseDb: begin
        if (key_down) begin
          state_d = StHeld;
        end else if (db_cnt_q == DbLast) begin
          state_d   = StIdle;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = sat_inc(db_cnt_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef KEY_EVENT_GEN_AUTOREPEAT_EN
  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE_CYCLES - 1);

  logic [CntW-1:0] rpt_cnt_q, rpt_cnt_d;
  // Set once the first (delay) repeat has fired; later repeats use the rate interval.
  logic            rpt_phase_q, rpt_phase_d;
  logic            repeat_q, repeat_d;

  always_ff @(posedge clk_btn or posedge rst_btn) begin
    if (rst_btn) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
      repeat_q    <= repeat_d;
    end
  end

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    repeat_d    = 1'b0;
    if (state_q == StPressDb && state_d == StHeld) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (state_q == StHeld && state_d == StHeld) begin
      if (rpt_cnt_q == (rpt_phase_q ? RateLast : DelayLast)) begin
        repeat_d    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_cnt_d = sat_inc(rpt_cnt_q);
      end
    end
  end

  assign advance_d    = press_d | repeat_d;
  assign repeat_pulse = repeat_q;
`else
  assign advance_d    = press_d;
  assign repeat_pulse = 1'b0;
`endif

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign advance       = advance_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen: press, glitch, bouncy release, auto-repeat, reset.
module tb_key_event_gen;

  localparam int Db       = 4;
  localparam int RptDelay = 20;
  localparam int RptRate  = 8;
`ifdef KEY_EVENT_GEN_AUTOREPEAT_EN
  localparam bit RptEn = 1'b1;
`else
  localparam bit RptEn = 1'b0;
`endif

  logic clk_btn = 1'b0;
  logic rst_btn = 1'b0;
  logic key_n   = 1'b1;
  logic key_level, press_pulse, release_pulse, repeat_pulse, advance;

  int vectors = 0;
  int errors  = 0;
  int edge_n  = 0;
  int k, p, rf;

  key_event_gen #(
    .DEBOUNCE_CYCLES    (Db),
    .REPEAT_DELAY_CYCLES(RptDelay),
    .REPEAT_RATE_CYCLES (RptRate)
  ) dut (
    .clk_btn      (clk_btn),
    .rst_btn      (rst_btn),
    .key_n        (key_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .advance      (advance)
  );

  always #5 clk_btn = ~clk_btn;

  task automatic step();
    @(posedge clk_btn);
    #1;
    edge_n++;
  endtask

  task automatic check(input string tag, input logic l, input logic pr, input logic rl,
                       input logic rp);
    logic [4:0] obs, exp;
    obs = {key_level, press_pulse, release_pulse, repeat_pulse, advance};
    exp = {l, pr, rl, rp, pr | rp};
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %b expected %b (level,press,release,repeat,advance)",
             tag, edge_n, obs, exp);
    end
  endtask

  // Expected repeat strobe d edges after the press edge while the key stays held.
  function automatic logic rpt_at(input int d);
    return RptEn && d >= RptDelay && ((d - RptDelay) % RptRate) == 0;
  endfunction

  initial begin
    #1 rst_btn = 1'b1;
    #1 check("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_btn = 1'b0;
    step();
    check("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean press held 56 edges past the press, then clean release.
    key_n = 1'b0;
    k = edge_n + 1;
    p = k + Db + 2;
    while (edge_n < p + 56) begin
      step();
      check("press_hold", edge_n >= p, edge_n == p, 1'b0, rpt_at(edge_n - p));
    end
    key_n = 1'b1;
    rf = edge_n + 1;
    while (edge_n < rf + Db + 4) begin
      step();
      check("release", edge_n < rf + Db + 2, 1'b0, edge_n == rf + Db + 2, 1'b0);
    end

    // Three-edge glitch must be rejected.
    key_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 3) key_n = 1'b1;
    end

    // Press, then a 1/0/1 bounce on release.
    key_n = 1'b0;
    k = edge_n + 1;
    p = k + Db + 2;
    while (edge_n < p + 2) begin
      step();
      check("press2", edge_n >= p, edge_n == p, 1'b0, 1'b0);
    end
    key_n = 1'b1;
    step();
    check("bounce_hi", 1'b1, 1'b0, 1'b0, 1'b0);
    key_n = 1'b0;
    step();
    check("bounce_lo", 1'b1, 1'b0, 1'b0, 1'b0);
    key_n = 1'b1;
    rf = edge_n + 1;
    while (edge_n < rf + Db + 4) begin
      step();
      check("bounce_release", edge_n < rf + Db + 2, 1'b0, edge_n == rf + Db + 2, 1'b0);
    end

    // Reset while held, key kept low through reset release.
    key_n = 1'b0;
    k = edge_n + 1;
    p = k + Db + 2;
    while (edge_n < p + 3) begin
      step();
      check("press3", edge_n >= p, edge_n == p, 1'b0, 1'b0);
    end
    rst_btn = 1'b1;
    #1 check("reset_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step();
      check("reset_mid_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_btn = 1'b0;
    k = edge_n + 1;
    p = k + Db + 2;
    while (edge_n < p + 3) begin
      step();
      check("press_after_reset", edge_n >= p, edge_n == p, 1'b0, 1'b0);
    end
    key_n = 1'b1;
    rf = edge_n + 1;
    while (edge_n < rf + Db + 4) begin
      step();
      check("final_release", edge_n < rf + Db + 2, 1'b0, edge_n == rf + Db + 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
